// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - ROM/RAM/IO memory bus controller with per-region wait states
// Optional feature macro: WRITE_PROTECT_EN (drop ROM-region writes and flag bus_err)
module mem_bus_ctrl #(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 0,
    parameter logic [15:0] ROM_TOP  = 16'h00FF,
    parameter logic [15:0] IO_BASE  = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_bus,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        bus_err,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  io_out
);

`ifdef WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {R_ROM, R_RAM, R_IO} region_t;

    state_t      state_q;
    region_t     region_q, region_d, acc_region;
    logic [15:0] addr_q, acc_addr, ram_addr_q, io_off;
    logic [7:0]  wdata_q, acc_wdata, rdata_q, rom_addr_q, ram_wdata_q, io_out_q, txn_cnt_q, rd_sel;
    logic [3:0]  wait_cnt_q, wait_d;
    logic        write_q, conflict_q, acc_write, acc_ram_wr;
    logic        ready_q, bus_err_q, ram_we_q, req, go_access;

    assign req = mem_read | mem_write;

    always_comb begin
        region_d = R_RAM;
        if (addr_bus <= ROM_TOP)
            region_d = R_ROM;
        else if (addr_bus >= IO_BASE)
            region_d = R_IO;
        case (region_d)
            R_ROM:   wait_d = ROM_W;
            R_IO:    wait_d = IO_W;
            default: wait_d = RAM_W;
        endcase
    end

    // Zero-wait requests enter ACCESS straight from IDLE, so the access
    // fields come from the live bus there and from the latches otherwise.
    always_comb begin
        acc_addr   = (state_q == S_IDLE) ? addr_bus  : addr_q;
        acc_region = (state_q == S_IDLE) ? region_d  : region_q;
        acc_write  = (state_q == S_IDLE) ? mem_write : write_q;
        acc_wdata  = (state_q == S_IDLE) ? wdata     : wdata_q;
        acc_ram_wr = acc_write && (acc_region == R_RAM || (acc_region == R_ROM && !WP));
        go_access  = (state_q == S_IDLE && req && wait_d == 4'd0) ||
                     (state_q == S_WAIT && wait_cnt_q == 4'd1);
    end

    always_comb begin
        io_off = addr_q - IO_BASE;
        case (region_q)
            R_ROM:   rd_sel = rom_rdata;
            R_RAM:   rd_sel = ram_rdata;
            default: rd_sel = (io_off == 16'd0) ? io_out_q :
                              (io_off == 16'd1) ? txn_cnt_q : 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            region_q    <= R_ROM;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            conflict_q  <= 1'b0;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            io_out_q    <= '0;
            txn_cnt_q   <= '0;
        end else begin
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q     <= addr_bus;
                        wdata_q    <= wdata;
                        write_q    <= mem_write;
                        conflict_q <= mem_read & mem_write;
                        region_q   <= region_d;
                        wait_cnt_q <= wait_d;
                        state_q    <= (wait_d == 4'd0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 4'd1)
                        state_q <= S_ACCESS;
                    else
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                end
                S_ACCESS: begin
                    ram_we_q  <= 1'b0;
                    ready_q   <= 1'b1;
                    bus_err_q <= conflict_q | (WP && write_q && region_q == R_ROM);
                    if (write_q && region_q == R_IO && io_off == 16'd0)
                        io_out_q <= wdata_q;
                    state_q <= S_DONE;
                end
                default: begin
                    txn_cnt_q <= txn_cnt_q + 8'd1;
                    if (!write_q)
                        rdata_q <= rd_sel;
                    state_q <= S_IDLE;
                end
            endcase
            if (go_access) begin
                rom_addr_q <= acc_addr[7:0];
                ram_addr_q <= acc_addr;
                ram_we_q   <= acc_ram_wr;
                if (acc_ram_wr)
                    ram_wdata_q <= acc_wdata;
            end
        end
    end

    // Synchronous memories return data during DONE, so read data is
    // forwarded in that cycle and held in rdata_q afterwards.
    assign rdata     = (state_q == S_DONE && !write_q) ? rd_sel : rdata_q;
    assign ready     = ready_q;
    assign bus_err   = bus_err_q;
    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign io_out    = io_out_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - table-driven scoreboard bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    typedef struct {
        logic [7:0]  rd;
        logic        err;
        int          lat;
        int          we;
        logic [15:0] waddr;
        logic [7:0]  wdat;
    } exp_t;

    logic        clk, reset, mem_read, mem_write, ready, bus_err, ram_we;
    logic [15:0] addr_bus, ram_addr;
    logic [7:0]  wdata, rdata, rom_addr, rom_rdata, ram_wdata, ram_rdata, io_out;
    logic [7:0]  ram_mem [0:65535];

    logic        rst3, rd3, wr3, ready3, bus_err3, ram_we3;
    logic [15:0] addr3, ram_addr3;
    logic [7:0]  wd3, rdata3, rom_addr3, ram_wdata3, io_out3;
    logic [7:0]  rom_rdata3 = 8'h00;
    logic [7:0]  ram_rdata3 = 8'h00;

    int   checks = 0;
    int   errors = 0;
    int   we_cnt, we3_cnt, rdy3_cnt;
    logic [15:0] we_addr;
    logic [7:0]  we_data, last_rd;
    exp_t sb[$];
    vec_t vt[19];

    mem_bus_ctrl u_dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .mem_read(mem_read),
        .mem_write(mem_write), .wdata(wdata), .rdata(rdata), .ready(ready),
        .bus_err(bus_err), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .io_out(io_out)
    );

    mem_bus_ctrl #(.RAM_WAIT(3)) u_dut3 (
        .clk(clk), .reset(rst3), .addr_bus(addr3), .mem_read(rd3),
        .mem_write(wr3), .wdata(wd3), .rdata(rdata3), .ready(ready3),
        .bus_err(bus_err3), .rom_addr(rom_addr3), .rom_rdata(rom_rdata3),
        .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .io_out(io_out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: rom[a] = a*3 + 0x52, so rom[1] = 0x55
    always @(posedge clk) begin
        rom_rdata <= rom_addr * 8'd3 + 8'h52;
        if (ram_we)
            ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = ram_addr;
            we_data = ram_wdata;
        end
        if (ram_we3)
            we3_cnt = we3_cnt + 1;
        if (ready3)
            rdy3_cnt = rdy3_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] a,
                                input logic [7:0] wd, input logic [7:0] er, input logic ee,
                                input int lat, input int we);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd;
        v.exp_rd = er; v.exp_err = ee; v.exp_lat = lat; v.exp_we = we;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t g;
        int   cyc;
        bit   got;
        e.rd    = (v.rd && !v.wr) ? v.exp_rd : last_rd;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        e.we    = v.exp_we;
        e.waddr = v.addr;
        e.wdat  = v.wd;
        if (v.rd && !v.wr)
            last_rd = v.exp_rd;
        sb.push_back(e);
        we_cnt    = 0;
        mem_read  = v.rd;
        mem_write = v.wr;
        addr_bus  = v.addr;
        wdata     = v.wd;
        cyc = 0;
        got = 0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (ready) got = 1;
        end
        g = sb.pop_front();
        if (!got) begin
            chk($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
        end else begin
            chk($sformatf("v%0d_latency", idx), cyc - 1, g.lat);
            chk($sformatf("v%0d_rdata", idx), rdata, g.rd);
            chk($sformatf("v%0d_bus_err", idx), bus_err, g.err);
            chk($sformatf("v%0d_ram_we_cycles", idx), we_cnt, g.we);
            if (g.we != 0) begin
                chk($sformatf("v%0d_ram_addr", idx), we_addr, g.waddr);
                chk($sformatf("v%0d_ram_wdata", idx), we_data, g.wdat);
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ready_one_cycle", idx), ready, 1'b0);
    endtask

    task automatic wait_ready3(input string nm, input int exp_lat);
        int cyc;
        bit got;
        cyc = 0;
        got = 0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (ready3) got = 1;
        end
        if (!got)
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        else
            chk({nm, "_latency"}, cyc - 1, exp_lat);
        rd3 = 1'b0;
        wr3 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = mk(1, 0, 16'h0001, 8'h00, 8'h55, 0, 2, 0);
        vt[1]  = mk(0, 1, 16'h0200, 8'hA5, 8'h00, 0, 1, 1);
        vt[2]  = mk(1, 0, 16'h0200, 8'h00, 8'hA5, 0, 1, 0);
        vt[3]  = mk(0, 1, 16'hFF00, 8'h3C, 8'h00, 0, 1, 0);
        vt[4]  = mk(1, 0, 16'hFF01, 8'h00, 8'h04, 0, 1, 0);
        vt[5]  = mk(1, 0, 16'hFF00, 8'h00, 8'h3C, 0, 1, 0);
`ifdef WRITE_PROTECT_EN
        vt[6]  = mk(0, 1, 16'h0010, 8'h77, 8'h00, 1, 2, 0);
`else
        vt[6]  = mk(0, 1, 16'h0010, 8'h77, 8'h00, 0, 2, 1);
`endif
        vt[7]  = mk(1, 1, 16'h0300, 8'h11, 8'h00, 1, 1, 1);
        vt[8]  = mk(1, 0, 16'h0300, 8'h00, 8'h11, 0, 1, 0);
        vt[9]  = mk(1, 0, 16'h00FF, 8'h00, 8'h4F, 0, 2, 0);
        vt[10] = mk(0, 1, 16'h0100, 8'h9C, 8'h00, 0, 1, 1);
        vt[11] = mk(1, 0, 16'h0100, 8'h00, 8'h9C, 0, 1, 0);
        vt[12] = mk(0, 1, 16'hFEFF, 8'h6B, 8'h00, 0, 1, 1);
        vt[13] = mk(1, 0, 16'hFEFF, 8'h00, 8'h6B, 0, 1, 0);
        vt[14] = mk(0, 1, 16'hFFFF, 8'hEE, 8'h00, 0, 1, 0);
        vt[15] = mk(1, 0, 16'hFFFF, 8'h00, 8'h00, 0, 1, 0);
        vt[16] = mk(1, 0, 16'hFF00, 8'h00, 8'h3C, 0, 1, 0);
        vt[17] = mk(1, 0, 16'hFF01, 8'h00, 8'h11, 0, 1, 0);
        vt[18] = mk(1, 0, 16'h0010, 8'h00, 8'h82, 0, 2, 0);

        reset = 1'b0; rst3 = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; addr_bus = '0; wdata = '0;
        rd3 = 1'b0; wr3 = 1'b0; addr3 = '0; wd3 = '0;
        we_cnt = 0; we3_cnt = 0; rdy3_cnt = 0; we_addr = '0; we_data = '0; last_rd = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {ready, bus_err, ram_we}, 3'b000);
        chk("reset_data", {rdata, io_out, rom_addr, ram_wdata}, 32'h0);
        chk("reset_ram_addr", ram_addr, 16'h0);
        reset = 1'b1; rst3 = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++)
            run_vec(i, vt[i]);
        chk("io_out_latch", io_out, 8'h3C);

        for (int i = 0; i < 236; i++)
            run_vec(100 + i, mk(1, 0, 16'h0200, 8'h00, 8'hA5, 0, 1, 0));
        run_vec(400, mk(1, 0, 16'hFF01, 8'h00, 8'hFF, 0, 1, 0));
        run_vec(401, mk(1, 0, 16'hFF01, 8'h00, 8'h00, 0, 1, 0));

        we3_cnt = 0;
        wr3 = 1'b1; addr3 = 16'h0400; wd3 = 8'h99;
        wait_ready3("w3_full_write", 4);
        chk("w3_full_we_cycles", we3_cnt, 1);
        chk("w3_full_ram_addr", ram_addr3, 16'h0400);
        chk("w3_full_ram_wdata", ram_wdata3, 8'h99);

        we3_cnt = 0; rdy3_cnt = 0;
        wr3 = 1'b1; addr3 = 16'h0500; wd3 = 8'h42;
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("abort_ctrl", {ready3, bus_err3, ram_we3}, 3'b000);
        chk("abort_data", {rdata3, io_out3, rom_addr3, ram_wdata3}, 32'h0);
        chk("abort_ram_addr", ram_addr3, 16'h0);
        wr3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_ram_we", we3_cnt, 0);
        chk("abort_no_ready", rdy3_cnt, 0);
        rd3 = 1'b1; addr3 = 16'h0400;
        wait_ready3("abort_then_idle", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
